fpu_div_sqrt_unit: RTL and testbench

Parametrised, iterative radix-2 restoring divider and square-root unit for FPU mantissas, one quotient/root bit per clock. Next-generation replacement for the fixed-width div/sqrt state machines in the FPU. Width is a parameter, both operations share one datapath, and the unit adds:
- div-by-zero and overflow flags
- remainder output
- synchronous flush
- result-hold/acknowledge handshake

It sits under the FPU arithmetic sequencer, which supplies aligned mantissas and handles exponents and signs.

---
 rtl/fpu_div_sqrt_unit_pkg.sv | 18 +
 rtl/div_sqrt_step.sv | 41 ++++
 rtl/fpu_div_sqrt_unit.sv | 159 +++++++++++++++
 tb/tb_fpu_div_sqrt_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_sqrt_unit_pkg.sv
// Shared FPU types for the iterative mantissa divide / square-root unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fpu_div_sqrt_unit_pkg;

    typedef enum logic [1:0] {
        ds_idle_st  = 2'd0,
        ds_load_st  = 2'd1,
        ds_iter_st  = 2'd2,
        ds_valid_st = 2'd3
    } e_div_sqrt_states;

    typedef enum logic {
        ds_op_div  = 1'b0,
        ds_op_sqrt = 1'b1
    } e_div_sqrt_op;

endpackage

// File: rtl/div_sqrt_step.sv
// One radix-2 restoring iteration shared by divide and square root.
// Latency: combinational.
// Backpressure: none; pure function of the current partial remainder and root.
module div_sqrt_step
    import fpu_div_sqrt_unit_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  e_div_sqrt_op       i_op,
    input  logic [WIDTH:0]     i_rem,
    input  logic [WIDTH-1:0]   i_root,
    input  logic [1:0]         i_bits,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH:0]     o_rem,
    output logic [WIDTH:0]     o_q
);

    // Wide enough for sqrt's (rem << 2) | bits; div uses one fewer bit.
    localparam int TW = WIDTH + 3;

    logic [TW-1:0] w_trial;
    logic [TW-1:0] w_sub;
    logic          w_ge;

    // Shifted partial remainder and subtrahend for the active mode
    always_comb begin
        w_trial = {1'b0, i_rem, i_bits[1]};
        w_sub   = {3'b000, i_b};
        if (i_op == ds_op_sqrt) begin
            w_trial = {i_rem, i_bits};
            w_sub   = {1'b0, i_root, 2'b01};
        end
    end

    // Keep the difference when non-negative, otherwise restore; the kept
    // value always fits WIDTH+1 bits in both modes.
    assign w_ge  = (w_trial >= w_sub);
    assign o_rem = w_ge ? (WIDTH+1)'(w_trial - w_sub) : w_trial[WIDTH:0];
    assign o_q   = {i_root, w_ge};

endmodule

// File: rtl/fpu_div_sqrt_unit.sv
// Iterative radix-2 mantissa divider / square root, one result bit per clock.
// Latency: div WIDTH+2, sqrt WIDTH+1, div-by-zero/overflow 2 cycles from start.
// Backpressure: result held in VALID until ack; start ignored unless idle.
module fpu_div_sqrt_unit
    import fpu_div_sqrt_unit_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    input  logic               ack,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH:0]     q,
    output logic [WIDTH:0]     rem,
    output logic               dz,
    output logic               ovf
);

    localparam int N_DIV  = WIDTH + 1;
    localparam int N_SQRT = WIDTH;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int SW     = 2 * WIDTH;
    localparam logic [CW-1:0] C_DIV_LAST  = CW'(N_DIV - 1);
    localparam logic [CW-1:0] C_SQRT_LAST = CW'(N_SQRT - 1);

    e_div_sqrt_states r_state;
    e_div_sqrt_op     r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_q;
    logic [WIDTH:0]   r_rem;
    logic [SW-1:0]    r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_valid;
    logic             r_dz;
    logic             r_ovf;

    logic             w_dz;
    logic             w_ovf;
    logic [WIDTH:0]   w_nrem;
    logic [WIDTH:0]   w_nq;

    // Quotient needs more than WIDTH+1 bits exactly when a >= 2b.
    assign w_dz  = (r_op == ds_op_div) && (r_b == '0);
    assign w_ovf = (r_op == ds_op_div) && !w_dz && ({1'b0, r_a} >= {r_b, 1'b0});

    div_sqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op   (r_op),
        .i_rem  (r_rem),
        .i_root (r_q[WIDTH-1:0]),
        .i_bits (r_sh[SW-1 -: 2]),
        .i_b    (r_b),
        .o_rem  (w_nrem),
        .o_q    (w_nq)
    );

    // Control FSM, iteration counter and datapath registers
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= ds_idle_st;
            r_op    <= ds_op_div;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_state <= ds_idle_st;
            r_q     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ds_idle_st: begin
                    // Operands captured here so the requester may move on at once.
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= e_div_sqrt_op'(op);
                        r_busy  <= 1'b1;
                        r_state <= ds_load_st;
                    end
                end
                ds_load_st: begin
                    r_dz    <= w_dz;
                    r_ovf   <= w_ovf;
                    r_state <= ds_iter_st;
                    if (w_dz || w_ovf) begin
                        // Flagged result spends a single frozen ITER slot.
                        r_q   <= '1;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end else if (r_op == ds_op_div) begin
                        r_q   <= '0;
                        r_rem <= {2'b00, r_a[WIDTH-1:1]};
                        r_sh  <= {r_a[0], {(SW-1){1'b0}}};
                        r_cnt <= C_DIV_LAST;
                    end else begin
                        r_q   <= '0;
                        r_rem <= '0;
                        r_sh  <= {r_a, {WIDTH{1'b0}}};
                        r_cnt <= C_SQRT_LAST;
                    end
                end
                ds_iter_st: begin
                    if (!(r_dz || r_ovf)) begin
                        r_rem <= w_nrem;
                        r_q   <= w_nq;
                        if (r_op == ds_op_div) begin
                            r_sh <= {r_sh[SW-2:0], 1'b0};
                        end else begin
                            r_sh <= {r_sh[SW-3:0], 2'b00};
                        end
                    end
                    if (r_cnt == '0) begin
                        r_valid <= 1'b1;
                        r_state <= ds_valid_st;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ds_valid_st: begin
                    if (ack) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_state <= ds_idle_st;
                    end
                end
                default: r_state <= ds_idle_st;
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign q     = r_q;
    assign rem   = r_rem;
    assign dz    = r_dz;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_fpu_div_sqrt_unit.sv
// Bench for fpu_div_sqrt_unit: three widths driven in parallel against a
// formula-level reference, plus literal results for the WIDTH=8 scenarios.
module tb_fpu_div_sqrt_unit;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] rem;
        logic        dz;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Result straight from the arithmetic definition.
    function automatic res_t ref_model(input int w, input bit o,
                                       input longint unsigned av, input longint unsigned bv);
        res_t              r;
        longint unsigned   d;
        longint unsigned   s;
        real               rd;
        r = '0;
        d = av << w;
        if (o) begin
            rd = d;
            s  = 64'($rtoi($sqrt(rd)));
            while ((s + 1) * (s + 1) <= d) s++;
            while (s * s > d) s--;
            r.q   = s;
            r.rem = d - s * s;
        end else if (bv == 0) begin
            r.dz = 1'b1;
            r.q  = (64'd1 << (w + 1)) - 1;
        end else if (av >= 2 * bv) begin
            r.ovf = 1'b1;
            r.q   = (64'd1 << (w + 1)) - 1;
        end else begin
            r.q   = d / bv;
            r.rem = d - r.q * bv;
        end
        return r;
    endfunction

    // Cycles from the accepting edge to the edge that raises valid.
    function automatic int ref_lat(input int w, input bit o,
                                   input longint unsigned av, input longint unsigned bv);
        if (o) return w + 1;
        if (bv == 0 || av >= 2 * bv) return 2;
        return w + 2;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 24;

        logic           arst  = 1'b0;
        logic           start = 1'b0;
        logic           op    = 1'b0;
        logic [W-1:0]   a     = '0;
        logic [W-1:0]   b     = '0;
        logic           flush = 1'b0;
        logic           ack   = 1'b0;
        logic           busy;
        logic           valid;
        logic [W:0]     q;
        logic [W:0]     rem;
        logic           dz;
        logic           ovf;
        bit             done = 1'b0;

        bit   m_busy  = 1'b0;
        bit   m_valid = 1'b0;
        bit   m_known = 1'b1;
        int   m_left  = 0;
        res_t m_res   = '0;
        res_t m_exp   = '0;

        fpu_div_sqrt_unit #(.WIDTH(W)) u_dut (
            .clk   (clk),
            .arst  (arst),
            .start (start),
            .op    (op),
            .a     (a),
            .b     (b),
            .flush (flush),
            .ack   (ack),
            .busy  (busy),
            .valid (valid),
            .q     (q),
            .rem   (rem),
            .dz    (dz),
            .ovf   (ovf)
        );

        // Reference: countdown to valid, result from the formula.
        always @(posedge clk or negedge arst) begin
            if (!arst || flush) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
                m_known <= 1'b1;
                m_left  <= 0;
                m_exp   <= '0;
            end else if (!m_busy) begin
                if (start) begin
                    m_res   <= ref_model(W, op, 64'(a), 64'(b));
                    m_left  <= ref_lat(W, op, 64'(a), 64'(b));
                    m_busy  <= 1'b1;
                    m_known <= 1'b0;
                end
            end else if (!m_valid) begin
                if (m_left == 1) begin
                    m_valid <= 1'b1;
                    m_known <= 1'b1;
                    m_exp   <= m_res;
                end
                m_left <= m_left - 1;
            end else if (ack) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
                m_known <= 1'b0;
            end
        end

        // Compare every cycle, results whenever they are defined.
        always @(negedge clk) begin
            check($sformatf("w%0d busy", W), 64'(busy), 64'(m_busy));
            check($sformatf("w%0d valid", W), 64'(valid), 64'(m_valid));
            if (m_known) begin
                check($sformatf("w%0d q", W), 64'(q), m_exp.q);
                check($sformatf("w%0d rem", W), 64'(rem), m_exp.rem);
                check($sformatf("w%0d dz", W), 64'(dz), 64'(m_exp.dz));
                check($sformatf("w%0d ovf", W), 64'(ovf), 64'(m_exp.ovf));
            end
        end

        task automatic run_op(input bit o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                              input int hold, input bit ack_start,
                              output logic [63:0] rq, output logic [63:0] rr,
                              output bit rdz, output bit rovf, output int lat);
            lat = -1;
            @(negedge clk);
            start = 1'b1; op = o; a = aa; b = bb;
            for (int c = 1; c <= W + 20; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 3) == 0);
                op = 1'($urandom); a = W'($urandom); b = W'($urandom);
                if (valid === 1'b1) begin
                    lat = c - 1;
                    break;
                end
            end
            if (lat < 0) check($sformatf("w%0d valid timeout", W), 64'(valid), 64'd1);
            rq = 64'(q); rr = 64'(rem); rdz = dz; rovf = ovf;
            repeat (hold) begin
                @(negedge clk);
                start = 1'($urandom);
            end
            ack   = 1'b1;
            start = ack_start ? 1'b1 : 1'($urandom);
            @(negedge clk);
            ack   = 1'b0;
            start = 1'b0;
        endtask

        task automatic rand_ops(input int n);
            logic [63:0]  rq;
            logic [63:0]  rr;
            bit           rdz;
            bit           rovf;
            int           lat;
            logic [W-1:0] aa;
            logic [W-1:0] bb;
            bit           o;
            for (int i = 0; i < n; i++) begin
                o  = 1'($urandom);
                aa = W'($urandom);
                bb = W'($urandom);
                case ($urandom_range(0, 7))
                    0:       bb = '0;
                    1, 2, 3: bb[W-1] = 1'b1;
                    default: ;
                endcase
                run_op(o, aa, bb, int'($urandom_range(0, 5)), 1'($urandom), rq, rr, rdz, rovf, lat);
            end
        endtask

        if (gi == 1) begin : g_dir
            task automatic dir(input string nm, input bit o, input logic [W-1:0] aa,
                               input logic [W-1:0] bb, input logic [63:0] eq,
                               input logic [63:0] erem, input bit edz, input bit eovf,
                               input int elat);
                logic [63:0] rq;
                logic [63:0] rr;
                bit          rdz;
                bit          rovf;
                int          lat;
                run_op(o, aa, bb, int'($urandom_range(0, 4)), 1'b1, rq, rr, rdz, rovf, lat);
                check({nm, " q"}, rq, eq);
                check({nm, " rem"}, rr, erem);
                check({nm, " dz"}, 64'(rdz), 64'(edz));
                check({nm, " ovf"}, 64'(rovf), 64'(eovf));
                check({nm, " latency"}, 64'(lat), 64'(elat));
                check({nm, " idle after ack"}, 64'(busy), 64'd0);
            endtask

            initial begin
                repeat (3) @(negedge clk);
                check("reset busy", 64'(busy), 64'd0);
                check("reset valid", 64'(valid), 64'd0);
                check("reset q", 64'(q), 64'd0);
                check("reset rem", 64'(rem), 64'd0);
                check("reset dz/ovf", 64'({dz, ovf}), 64'd0);
                arst = 1'b1;

                dir("div c0/80", 1'b0, 8'hC0, 8'h80, 64'h180, 64'd0, 1'b0, 1'b0, 10);
                dir("div 5/7",   1'b0, 8'd5,  8'd7,  64'd182, 64'd6, 1'b0, 1'b0, 10);
                dir("div ovf",   1'b0, 8'd100, 8'd7, 64'h1FF, 64'd0, 1'b0, 1'b1, 2);
                dir("div dz",    1'b0, 8'h55, 8'd0,  64'h1FF, 64'd0, 1'b1, 1'b0, 2);
                dir("sqrt 40",   1'b1, 8'h40, 8'd9,  64'd128, 64'd0, 1'b0, 1'b0, 9);
                dir("sqrt 2",    1'b1, 8'd2,  8'd0,  64'd22,  64'd28, 1'b0, 1'b0, 9);

                // Flush sampled at the edge ending the fourth ITER cycle.
                @(negedge clk);
                start = 1'b1; op = 1'b0; a = 8'd5; b = 8'd7;
                @(negedge clk);
                start = 1'b0;
                repeat (4) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                check("flush busy", 64'(busy), 64'd0);
                check("flush valid", 64'(valid), 64'd0);
                check("flush q/rem", 64'({q, rem}), 64'd0);
                check("flush dz/ovf", 64'({dz, ovf}), 64'd0);
                repeat (15) @(negedge clk);
                check("flush no valid", 64'(valid), 64'd0);
                dir("post-flush div", 1'b0, 8'd5, 8'd7, 64'd182, 64'd6, 1'b0, 1'b0, 10);

                // Asynchronous reset in the middle of a square root.
                @(negedge clk);
                start = 1'b1; op = 1'b1; a = 8'd2;
                @(negedge clk);
                start = 1'b0;
                repeat (3) @(negedge clk);
                #2 arst = 1'b0;
                #1;
                check("arst busy", 64'(busy), 64'd0);
                check("arst q/rem", 64'({q, rem}), 64'd0);
                @(negedge clk);
                arst = 1'b1;
                repeat (2) @(negedge clk);
                dir("post-arst sqrt", 1'b1, 8'd2, 8'd0, 64'd22, 64'd28, 1'b0, 1'b0, 9);

                rand_ops(30);
                done = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                repeat (3) @(negedge clk);
                arst = 1'b1;
                rand_ops(30);
                done = 1'b1;
            end
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (g_w[0].done && g_w[1].done && g_w[2].done) break;
        end
        if (!(g_w[0].done && g_w[1].done && g_w[2].done)) begin
            n_chk++;
            n_err++;
            $display("FAIL run timeout: got not done, expected all widths done");
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
